// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
//   Shared definitions for the pipeline hazard controller.
//   - state_t       : FSM state encoding (RUN / FREEZE / FLUSH)
//   - FLUSH_MIN/MAX : legal range for the per-branch IF/ID flush length
//   - flush_cycles_ok / flush_reload : range check and flush_left reload value
// -----------------------------------------------------------------------------
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FREEZE = 2'd1,
    ST_FLUSH  = 2'd2
  } state_t;

  localparam int FLUSH_MIN = 1;
  localparam int FLUSH_MAX = 7;

  // True when a FLUSH_CYCLES value fits the 3-bit flush_left counter.
  function automatic bit flush_cycles_ok(input int cycles);
    return (cycles >= FLUSH_MIN) && (cycles <= FLUSH_MAX);
  endfunction

  // Value loaded into flush_left when a branch redirects the front end.
  // The redirect cycle itself is the first flush cycle, so the remaining
  // count is cycles-1. Out-of-range values are clamped into 1..7 so the
  // counter can never wrap.
  function automatic logic [2:0] flush_reload(input int cycles);
    int clamped;
    clamped = cycles;
    if (clamped < FLUSH_MIN) clamped = FLUSH_MIN;
    if (clamped > FLUSH_MAX) clamped = FLUSH_MAX;
    return 3'(clamped - 1);
  endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// -----------------------------------------------------------------------------
// hazard_perf_cnt
//   Saturating event counter used for hazard performance monitoring.
//   Ports:
//     clk    in   core clock, rising edge
//     rst_n  in   asynchronous active-low reset (count -> 0)
//     inc    in   count one event this cycle
//     count  out  CNT_W-bit event count, sticks at all-ones
// -----------------------------------------------------------------------------
module hazard_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Stall/flush controller for the 5-stage MIPS pipeline. Combines load-use
//   hits from the forwarding unit, the EX-stage branch redirect and the data
//   memory handshake into pipeline-register enables that act in the same
//   cycle. A small FSM (RUN / FREEZE / FLUSH) remembers memory freezes and
//   multi-cycle branch flushes.
//
//   Parameters:
//     FLUSH_CYCLES  IF/ID flush cycles per taken branch/jump (1..7)
//     CNT_W         performance counter width (HAZARD_PERF_EN only)
//
//   Build option:
//     HAZARD_PERF_EN  when defined, adds stall_cnt / flush_cnt / freeze_cnt
//                     saturating counters and their ports.
//
//   Ports:
//     clk, rst_n          clock and asynchronous active-low reset
//     c_rs_if, c_rt_if    load-use hits on the IF/ID rs / rt operands
//     rs_used, rt_used    ID instruction really reads rs / rt
//     branch_taken        EX resolved a taken branch/jump this cycle
//     dmem_req            MEM stage issues a load/store this cycle
//     dmem_ready          data memory completes the request this cycle
//     pc_we, if_id_we     front-end write enables
//     if_id_flush         IF/ID loads a NOP
//     id_ex_bubble        ID/EX loads all-zero control
//     ex_mem_we, mem_wb_we back-end write enables
//     stall_cnt, flush_cnt, freeze_cnt  event counters (HAZARD_PERF_EN)
// -----------------------------------------------------------------------------
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             c_rs_if,
  input  logic             c_rt_if,
  input  logic             rs_used,
  input  logic             rt_used,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_we,
  output logic             mem_wb_we
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt
`endif
);

  // Remaining flush cycles loaded on a redirect; zero means a single-cycle
  // flush that never needs the FLUSH state.
  localparam logic [2:0] FLUSH_RELOAD = flush_reload(FLUSH_CYCLES);
  localparam bit         MULTI_FLUSH  = (FLUSH_RELOAD != 3'd0);
  localparam bit         FLUSH_CFG_OK = flush_cycles_ok(FLUSH_CYCLES);

  state_t     state, state_next;
  logic [2:0] flush_left, flush_left_next;

  logic load_use;
  logic mem_wait;
  logic in_flush;

  // Unregistered control before the reset override.
  logic pc_we_c;
  logic if_id_we_c;
  logic if_id_flush_c;
  logic id_ex_bubble_c;
  logic ex_mem_we_c;
  logic mem_wb_we_c;

  assign load_use = (c_rs_if & rs_used) | (c_rt_if & rt_used);
  assign mem_wait = dmem_req & ~dmem_ready;

  // FREEZE has no rules of its own once memory is ready: the exit cycle
  // behaves as FLUSH when a flush was interrupted, otherwise as RUN.
  assign in_flush = (state == ST_FLUSH) ||
                    ((state == ST_FREEZE) && (flush_left != 3'd0));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_RUN;
      flush_left <= 3'd0;
    end else begin
      state      <= state_next;
      flush_left <= flush_left_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and control. Priority: memory wait > branch flush > load-use.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next      = state;
    flush_left_next = flush_left;
    pc_we_c         = 1'b1;
    if_id_we_c      = 1'b1;
    if_id_flush_c   = 1'b0;
    id_ex_bubble_c  = 1'b0;
    ex_mem_we_c     = 1'b1;
    mem_wb_we_c     = 1'b1;

    if (mem_wait) begin
      // Whole pipeline holds; any branch in EX is still there when the
      // freeze ends, so it is ignored here rather than lost.
      pc_we_c     = 1'b0;
      if_id_we_c  = 1'b0;
      ex_mem_we_c = 1'b0;
      mem_wb_we_c = 1'b0;
      state_next  = ST_FREEZE;
    end else if (branch_taken) begin
      // Redirect squashes both the fetched and the decoded wrong-path
      // instruction; a simultaneous load-use stall is moot.
      if_id_flush_c  = 1'b1;
      id_ex_bubble_c = 1'b1;
      if (MULTI_FLUSH) begin
        flush_left_next = FLUSH_RELOAD;
        state_next      = ST_FLUSH;
      end else begin
        flush_left_next = 3'd0;
        state_next      = ST_RUN;
      end
    end else if (in_flush) begin
      if_id_flush_c   = 1'b1;
      flush_left_next = flush_left - 3'd1;
      state_next      = (flush_left == 3'd1) ? ST_RUN : ST_FLUSH;
    end else if (load_use) begin
      // One bubble is enough: next cycle the load sits in EX/MEM and the
      // forwarding unit no longer reports a load-use hit.
      pc_we_c        = 1'b0;
      if_id_we_c     = 1'b0;
      id_ex_bubble_c = 1'b1;
      state_next     = ST_RUN;
    end else begin
      state_next = ST_RUN;
    end
  end

  // While in reset the pipeline is held and filled with NOPs.
  assign pc_we        = rst_n & pc_we_c;
  assign if_id_we     = rst_n & if_id_we_c;
  assign ex_mem_we    = rst_n & ex_mem_we_c;
  assign mem_wb_we    = rst_n & mem_wb_we_c;
  assign if_id_flush  = ~rst_n | if_id_flush_c;
  assign id_ex_bubble = ~rst_n | id_ex_bubble_c;

`ifdef HAZARD_PERF_EN
  // ---------------------------------------------------------------------------
  // Performance counters: [0] load-use stall, [1] IF/ID flush, [2] freeze.
  // A bubble without a flush only occurs for a load-use stall.
  // ---------------------------------------------------------------------------
  logic [2:0]       perf_inc;
  logic [CNT_W-1:0] perf_count [3];

  assign perf_inc[0] = rst_n & id_ex_bubble_c & ~if_id_flush_c;
  assign perf_inc[1] = rst_n & if_id_flush_c;
  assign perf_inc[2] = rst_n & mem_wait;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_perf
      hazard_perf_cnt #(
        .CNT_W (CNT_W)
      ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (perf_inc[gi]),
        .count (perf_count[gi])
      );
    end
  endgenerate

  assign stall_cnt  = perf_count[0];
  assign flush_cnt  = perf_count[1];
  assign freeze_cnt = perf_count[2];
`else
  localparam int unused_cnt_w = CNT_W;
`endif

  // Out-of-range FLUSH_CYCLES is clamped by flush_reload; the flag keeps
  // the configured intent visible to anyone probing the hierarchy.
  localparam bit unused_flush_cfg_ok = FLUSH_CFG_OK;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//   Directed bench for hazard_ctrl with FLUSH_CYCLES=2. A behavioural model
//   (remaining-flush count plus event tallies) predicts the outputs and is
//   compared on every falling edge; literal expectations after each directed
//   vector pin the model. Counter ports are checked when HAZARD_PERF_EN is
//   defined.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int FC    = 2;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic c_rs_if, c_rt_if, rs_used, rt_used, branch_taken, dmem_req, dmem_ready;
  logic pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_mem_we, mem_wb_we;
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt, freeze_cnt;
`endif

  always #5 clk = ~clk;

  hazard_ctrl #(
    .FLUSH_CYCLES (FC),
    .CNT_W        (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .c_rs_if      (c_rs_if),
    .c_rt_if      (c_rt_if),
    .rs_used      (rs_used),
    .rt_used      (rt_used),
    .branch_taken (branch_taken),
    .dmem_req     (dmem_req),
    .dmem_ready   (dmem_ready),
    .pc_we        (pc_we),
    .if_id_we     (if_id_we),
    .if_id_flush  (if_id_flush),
    .id_ex_bubble (id_ex_bubble),
    .ex_mem_we    (ex_mem_we),
    .mem_wb_we    (mem_wb_we)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt),
    .freeze_cnt   (freeze_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Output vector order: {pc_we, if_id_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_bubble}
  function automatic logic [5:0] outs();
    return {pc_we, if_id_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_bubble};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: the only memory the rules need is how many flush
  // cycles are still owed after a redirect; a freeze simply postpones them.
  // ---------------------------------------------------------------------------
  int m_flush_rem = 0;
  int m_stall = 0, m_flush = 0, m_freeze = 0;

  always @(negedge clk) begin : model
    logic [5:0] e;
    logic lu, mw;
    int   rem_next;
    lu = (c_rs_if && rs_used) || (c_rt_if && rt_used);
    mw = dmem_req && !dmem_ready;
    rem_next = m_flush_rem;
    if (!rst_n) begin
      e = 6'b000011;
    end else if (mw) begin
      e = 6'b000000;
    end else if (branch_taken) begin
      e = 6'b111111;
      rem_next = FC - 1;
    end else if (m_flush_rem > 0) begin
      e = 6'b111110;
      rem_next = m_flush_rem - 1;
    end else if (lu) begin
      e = 6'b001101;
    end else begin
      e = 6'b111100;
    end
    chk("model_outputs", 32'(outs()), 32'(e));
`ifdef HAZARD_PERF_EN
    chk("model_stall_cnt", 32'(stall_cnt), 32'(m_stall));
    chk("model_flush_cnt", 32'(flush_cnt), 32'(m_flush));
    chk("model_freeze_cnt", 32'(freeze_cnt), 32'(m_freeze));
`endif
    if (!rst_n) begin
      m_flush_rem = 0;
      m_stall = 0; m_flush = 0; m_freeze = 0;
    end else begin
      m_flush_rem = rem_next;
      if (e == 6'b001101) m_stall++;
      if (e[1])           m_flush++;
      if (mw)             m_freeze++;
    end
  end

  // Drive one cycle of inputs just after the rising edge.
  task automatic cyc(input logic rs, input logic rt, input logic rsu, input logic rtu,
                     input logic br, input logic req, input logic rdy, input string tag);
    @(posedge clk);
    #1;
    c_rs_if = rs; c_rt_if = rt; rs_used = rsu; rt_used = rtu;
    branch_taken = br; dmem_req = req; dmem_ready = rdy;
    $display("[%0t] %-18s rs=%b rt=%b rsu=%b rtu=%b br=%b req=%b rdy=%b",
             $time, tag, rs, rt, rsu, rtu, br, req, rdy);
  endtask

  task automatic lit(input string name, input logic [5:0] exp);
    #1;
    chk(name, 32'(outs()), 32'(exp));
  endtask

  typedef struct {
    logic [6:0] v;   // {rs, rt, rsu, rtu, br, req, rdy}
  } vec_t;
  vec_t table_v[8];

  initial begin
    rst_n = 1'b0;
    c_rs_if = 0; c_rt_if = 0; rs_used = 0; rt_used = 0;
    branch_taken = 0; dmem_req = 0; dmem_ready = 0;

    // Reset values while held in reset
    lit("reset_outputs", 6'b000011);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    cyc(0,0,0,0,0,0,0, "idle");         lit("run_idle", 6'b111100);

    // Load-use on rs: one stall cycle, then normal
    cyc(1,0,1,0,0,0,0, "load_use_rs");  lit("load_use_rs", 6'b001101);
    cyc(0,0,0,0,0,0,0, "after_stall");  lit("after_stall", 6'b111100);
    // rt hit but rt not read: no stall
    cyc(0,1,0,0,0,0,0, "rt_unused");    lit("rt_unused", 6'b111100);
    cyc(0,1,0,1,0,0,0, "load_use_rt");  lit("load_use_rt", 6'b001101);

    // Two-cycle branch flush, bubble only on the redirect cycle
    cyc(0,0,0,0,1,0,0, "branch");       lit("br_flush1", 6'b111111);
    cyc(0,0,0,0,0,0,0, "flush2");       lit("br_flush2", 6'b111110);
    cyc(0,0,0,0,0,0,0, "br_done");      lit("br_done", 6'b111100);

    // Three-cycle memory freeze
    for (int i = 0; i < 3; i++) begin
      cyc(0,0,0,0,0,1,0, "mem_wait");   lit("freeze", 6'b000000);
    end
    cyc(0,0,0,0,0,1,1, "mem_ready");    lit("freeze_exit", 6'b111100);

    // Branch beats load-use; freeze mid-flush holds the remaining flush
    cyc(1,0,1,0,1,0,0, "br_and_lu");    lit("br_beats_lu", 6'b111111);
    cyc(0,0,0,0,0,1,0, "wait_in_flush");lit("freeze_in_flush", 6'b000000);
    cyc(0,0,0,0,1,1,0, "br_while_frz"); lit("br_ignored_frozen", 6'b000000);
    cyc(1,0,1,0,0,1,1, "resume_lu");    lit("flush_resume", 6'b111110);
    cyc(0,0,0,0,0,0,0, "post_resume");  lit("post_resume", 6'b111100);

    // Branch seen on the freeze exit cycle
    cyc(0,0,0,0,1,1,0, "frz_with_br");  lit("frz_with_br", 6'b000000);
    cyc(0,0,0,0,1,1,1, "exit_br");      lit("exit_branch", 6'b111111);
    cyc(0,0,0,0,0,0,0, "exit_flush2");  lit("exit_flush2", 6'b111110);
    cyc(0,0,0,0,0,0,0, "exit_done");    lit("exit_done", 6'b111100);

    // Reset in the middle of a flush
    cyc(0,0,0,0,1,0,0, "branch_rst");   lit("br_before_rst", 6'b111111);
    @(posedge clk);
    #1 branch_taken = 0;
    #1 rst_n = 1'b0;
    $display("[%0t] %-18s rst_n=0", $time, "reset_mid_flush");
    lit("reset_mid_flush", 6'b000011);
    @(posedge clk);
    #1 rst_n = 1'b1;
    lit("post_reset_run", 6'b111100);

    // Mixed directed vectors, checked by the model only
    table_v[0].v = 7'b1010000;  // load-use rs
    table_v[1].v = 7'b0000001;  // ready without request
    table_v[2].v = 7'b0101100;  // branch + load-use rt
    table_v[3].v = 7'b1111000;  // load-use during flush
    table_v[4].v = 7'b0000010;  // memory wait
    table_v[5].v = 7'b1010011;  // load-use on freeze exit
    table_v[6].v = 7'b0000000;  // idle
    table_v[7].v = 7'b0000100;  // branch
    foreach (table_v[k]) begin
      cyc(table_v[k].v[6], table_v[k].v[5], table_v[k].v[4], table_v[k].v[3],
          table_v[k].v[2], table_v[k].v[1], table_v[k].v[0], "table");
    end
    cyc(0,0,0,0,0,0,0, "drain");
    cyc(0,0,0,0,0,0,0, "drain");
    @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
